// File: rtl/boxcar_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : boxcar_seq_ctrl_if
// Purpose  : Sample-in / result-out stream bundle for boxcar_seq_ctrl.
//            Signal names follow the controller's point of view.
// Revision : 1.0  initial release
// ============================================================================
interface boxcar_seq_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 9
);
    logic                  i_s_valid;
    logic                  o_s_ready;
    logic [DATA_WIDTH-1:0] i_s_data;
    logic                  o_m_valid;
    logic                  i_m_ready;
    logic [OUT_WIDTH-1:0]  o_m_data;

    modport slave (
        input  i_s_valid, i_s_data, i_m_ready,
        output o_s_ready, o_m_valid, o_m_data
    );

    modport master (
        output i_s_valid, i_s_data, i_m_ready,
        input  o_s_ready, o_m_valid, o_m_data
    );
endinterface
`default_nettype wire

// File: rtl/boxcar_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : boxcar_seq_ctrl
// Purpose  : Start/flush/run/drain sequencer for one boxcar filter with
//            warm-up tracking, runtime decimation and a buffered output.
// Options  : BOXCAR_SEQ_CTRL_STATS_EN adds accept/drop counters.
// Revision : 1.0  initial release
// ============================================================================
module boxcar_seq_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_SAMPLES = 2,
    parameter int OUT_WIDTH   = DATA_WIDTH + $clog2(NUM_SAMPLES),
    parameter int DIV_WIDTH   = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  wire                   i_clk,
    input  wire                   i_reset_n,
    input  wire                   i_start,
    input  wire                   i_stop,
    input  wire  [DIV_WIDTH-1:0]  i_div,
    boxcar_seq_ctrl_if.slave      bus,
    output logic                  o_filt_reset_n,
    output logic                  o_filt_ce,
    output logic [DATA_WIDTH-1:0] o_filt_data,
    input  wire                   i_filt_ce,
    input  wire  [OUT_WIDTH-1:0]  i_filt_data,
    output logic                  o_busy,
    output logic                  o_sync_err
`ifdef BOXCAR_SEQ_CTRL_STATS_EN
    ,
    output logic [15:0]           o_accept_count,
    output logic [15:0]           o_drop_count
`endif
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FLUSH = 2'd1;
    localparam logic [1:0] c_RUN   = 2'd2;
    localparam logic [1:0] c_DRAIN = 2'd3;

    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_WARM_W = $clog2(NUM_SAMPLES + 1);
    localparam logic [c_WARM_W-1:0]  c_WARM_FULL = c_WARM_W'(NUM_SAMPLES);
    localparam logic [c_PTR_W+1:0]   c_DEPTH     = (c_PTR_W + 2)'(FIFO_DEPTH);
    localparam logic [DIV_WIDTH-1:0] c_DIV_ONE   = DIV_WIDTH'(1);

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic                  r_flush_cnt;
    logic [DIV_WIDTH-1:0]  r_div_q;
    logic [DIV_WIDTH-1:0]  r_dec_cnt;
    logic [c_WARM_W-1:0]   r_warm_cnt;

    logic                  r_p0_vld, r_p0_exp, r_p0_fwd;
    logic                  r_p1_vld, r_p1_exp, r_p1_fwd;

    logic [c_PTR_W:0]      r_wptr, r_rptr;
    logic [OUT_WIDTH-1:0]  r_mem [FIFO_DEPTH];
    logic [c_PTR_W:0]      w_fifo_count;
    logic [1:0]            w_inflight;

    logic                  w_start, w_s_ready, w_accept, w_exp_new, w_fwd_new;
    logic                  w_m_valid, w_push, w_pop;
    logic                  r_filt_reset_n, r_filt_ce, r_sync_err;
    logic [DATA_WIDTH-1:0] r_filt_data;

    assign w_fifo_count = r_wptr - r_rptr;
    assign w_inflight   = {1'b0, r_p0_fwd} + {1'b0, r_p1_fwd};
    assign w_start      = (r_state == c_IDLE) && i_start && !i_stop;
    assign w_accept     = bus.i_s_valid && w_s_ready;
    assign w_exp_new    = (r_warm_cnt == c_WARM_FULL);
    assign w_fwd_new    = w_exp_new && (r_dec_cnt == '0);
    assign w_m_valid    = (w_fifo_count != '0);
    assign w_pop        = w_m_valid && bus.i_m_ready;
    // The space check at accept time guarantees room, except when full and popping.
    assign w_push       = r_p1_vld && r_p1_fwd &&
                          ((w_fifo_count != c_DEPTH[c_PTR_W:0]) || w_pop);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= c_IDLE;
            r_flush_cnt <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_flush_cnt <= (r_state == c_FLUSH) ? ~r_flush_cnt : 1'b0;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (w_start) w_next_state = c_FLUSH;
            c_FLUSH: if (r_flush_cnt) w_next_state = c_RUN;
            c_RUN:   if (i_stop) w_next_state = c_DRAIN;
            // The stage-1 entry lands in the FIFO on this edge, so only stage 0 can still be owed.
            c_DRAIN: if (!r_p0_fwd) w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        o_busy    = (r_state != c_IDLE);
        w_s_ready = (r_state == c_RUN) &&
                    (({1'b0, w_fifo_count} + (c_PTR_W + 2)'(w_inflight)) < c_DEPTH);
    end

    // ---------------- run control, shadow pipe, filter drive ----------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_filt_reset_n <= 1'b0;
            r_filt_ce      <= 1'b0;
            r_filt_data    <= '0;
            r_div_q        <= c_DIV_ONE;
            r_dec_cnt      <= '0;
            r_warm_cnt     <= '0;
            r_sync_err     <= 1'b0;
            r_p0_vld       <= 1'b0;
            r_p0_exp       <= 1'b0;
            r_p0_fwd       <= 1'b0;
            r_p1_vld       <= 1'b0;
            r_p1_exp       <= 1'b0;
            r_p1_fwd       <= 1'b0;
        end else begin
            r_filt_reset_n <= (w_next_state != c_FLUSH);
            r_filt_ce      <= w_accept;
            if (w_accept) r_filt_data <= bus.i_s_data;

            r_p0_vld <= w_accept;
            r_p0_exp <= w_accept && w_exp_new;
            r_p0_fwd <= w_accept && w_fwd_new;
            r_p1_vld <= r_p0_vld;
            r_p1_exp <= r_p0_exp;
            r_p1_fwd <= r_p0_fwd;

            if (w_start) begin
                r_div_q    <= (i_div == '0) ? c_DIV_ONE : i_div;
                r_dec_cnt  <= '0;
                r_warm_cnt <= '0;
                r_sync_err <= 1'b0;
            end else if (w_accept) begin
                if (!w_exp_new) r_warm_cnt <= r_warm_cnt + 1'b1;
                else r_dec_cnt <= (r_dec_cnt >= r_div_q - 1'b1) ? '0 : r_dec_cnt + 1'b1;
            end

            if (r_p1_vld && (i_filt_ce != r_p1_exp)) r_sync_err <= 1'b1;
        end
    end

    // ---------------- result FIFO ----------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr[c_PTR_W-1:0]] <= i_filt_data;
    end

`ifdef BOXCAR_SEQ_CTRL_STATS_EN
    logic [15:0] r_accept_cnt, r_drop_cnt;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_accept_cnt <= '0;
            r_drop_cnt   <= '0;
        end else if (w_start) begin
            r_accept_cnt <= '0;
            r_drop_cnt   <= '0;
        end else if (w_accept) begin
            if (r_accept_cnt != 16'hFFFF) r_accept_cnt <= r_accept_cnt + 1'b1;
            if (w_exp_new && !w_fwd_new && (r_drop_cnt != 16'hFFFF))
                r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign o_accept_count = r_accept_cnt;
    assign o_drop_count   = r_drop_cnt;
`endif

    assign bus.o_s_ready  = w_s_ready;
    assign bus.o_m_valid  = w_m_valid;
    assign bus.o_m_data   = w_m_valid ? r_mem[r_rptr[c_PTR_W-1:0]] : '0;
    assign o_filt_reset_n = r_filt_reset_n;
    assign o_filt_ce      = r_filt_ce;
    assign o_filt_data    = r_filt_data;
    assign o_sync_err     = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_boxcar_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_boxcar_seq_ctrl
// Purpose  : Randomised self-checking bench for boxcar_seq_ctrl with an
//            attached 2-tap averaging filter and a queue-based reference.
// Revision : 1.0  initial release
// ============================================================================
module tb_boxcar_seq_ctrl;
    localparam int DW = 8, NS = 2, OW = 9, DIVW = 8, DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, stop = 1'b0;
    logic [DIVW-1:0] div = '0;
    logic filt_reset_n, filt_ce, busy, sync_err;
    logic [DW-1:0] filt_data;
    logic f_ce = 1'b0;
    logic [OW-1:0] f_data = '0;
`ifdef BOXCAR_SEQ_CTRL_STATS_EN
    logic [15:0] acc_cnt, drop_cnt;
`endif

    always #5 clk = ~clk;

    boxcar_seq_ctrl_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) bus ();

    boxcar_seq_ctrl #(
        .DATA_WIDTH(DW), .NUM_SAMPLES(NS), .OUT_WIDTH(OW),
        .DIV_WIDTH(DIVW), .FIFO_DEPTH(DEPTH)
    ) u_dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_start        (start),
        .i_stop         (stop),
        .i_div          (div),
        .bus            (bus),
        .o_filt_reset_n (filt_reset_n),
        .o_filt_ce      (filt_ce),
        .o_filt_data    (filt_data),
        .i_filt_ce      (f_ce),
        .i_filt_data    (f_data),
        .o_busy         (busy),
        .o_sync_err     (sync_err)
`ifdef BOXCAR_SEQ_CTRL_STATS_EN
        ,
        .o_accept_count (acc_cnt),
        .o_drop_count   (drop_cnt)
`endif
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [OW-1:0] avg2(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        return OW'(s >>> 1);
    endfunction

    // Attached filter: 2-tap average, result strobed once the window has history.
    bit glitch = 1'b0;
    int f_idx = 0;
    logic [DW-1:0] f_prev = '0;
    always @(posedge clk) begin
        if (!rst_n || !filt_reset_n) begin
            f_idx  <= 0;
            f_ce   <= 1'b0;
            f_data <= '0;
        end else begin
            f_ce <= 1'b0;
            if (filt_ce) begin
                f_ce   <= (f_idx >= NS) || glitch;
                f_data <= avg2(f_prev, filt_data);
                f_prev <= filt_data;
                f_idx  <= f_idx + 1;
            end
        end
    end

    // Reference: k-th accepted sample yields a result when k >= NS and (k-NS) % div == 0.
    logic [OW-1:0] exp_q[$];
    int m_idx = 0, m_div = 1, m_drop = 0, m_acc = 0;
    logic [DW-1:0] m_prev = '0;
    bit run_flag = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (start) begin
                m_idx = 0; m_drop = 0; m_acc = 0;
                m_div = (div == '0) ? 1 : int'(div);
            end
            if (run_flag) chk_eq("s_ready", bus.o_s_ready, exp_q.size() < DEPTH);
            if (bus.i_s_valid && bus.o_s_ready) begin
                if (m_idx >= NS) begin
                    if (((m_idx - NS) % m_div) == 0) exp_q.push_back(avg2(m_prev, bus.i_s_data));
                    else m_drop++;
                end
                m_prev = bus.i_s_data;
                m_idx++;
                m_acc++;
            end
            if (bus.o_m_valid && bus.i_m_ready) begin
                if (exp_q.size() == 0) chk_eq("extra_out", bus.o_m_valid, 1'b0);
                else chk_eq("m_data", bus.o_m_data, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [DIVW-1:0] d);
        start = 1'b1; div = d;
        step();
        start = 1'b0;
        chk_eq("flush_lo1", filt_reset_n, 1'b0);
        chk_eq("busy_flush", busy, 1'b1);
        step();
        chk_eq("flush_lo2", filt_reset_n, 1'b0);
        step();
        chk_eq("flush_hi", filt_reset_n, 1'b1);
        run_flag = 1'b1;
    endtask

    task automatic send_one(input logic [DW-1:0] v);
        bit ok;
        bus.i_s_valid = 1'b1;
        bus.i_s_data  = v;
        for (int k = 0; k < 64; k++) begin
            ok = bus.o_s_ready;
            step();
            if (ok) break;
            if (k == 63) chk_eq("send_timeout", bus.o_s_ready, 1'b1);
        end
        bus.i_s_valid = 1'b0;
    endtask

    task automatic stream(input int cycles, input int pv, input int pr);
        for (int k = 0; k < cycles; k++) begin
            bus.i_s_valid = ($urandom_range(99) < pv);
            bus.i_s_data  = DW'($urandom);
            bus.i_m_ready = ($urandom_range(99) < pr);
            step();
        end
        bus.i_s_valid = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
        run_flag = 1'b0;
    endtask

    task automatic drain(input int bound);
        int k;
        bus.i_m_ready = 1'b1;
        k = 0;
        while ((exp_q.size() != 0 || bus.o_m_valid || busy) && k < bound) begin
            step();
            k++;
        end
        chk_eq("drain_done", (exp_q.size() == 0) && !bus.o_m_valid && !busy, 1'b1);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk_eq({tag, "_s_ready"}, bus.o_s_ready, 1'b0);
        chk_eq({tag, "_filt_ce"}, filt_ce, 1'b0);
        chk_eq({tag, "_filt_rst_n"}, filt_reset_n, 1'b0);
        chk_eq({tag, "_filt_data"}, filt_data, '0);
        chk_eq({tag, "_m_valid"}, bus.o_m_valid, 1'b0);
        chk_eq({tag, "_m_data"}, bus.o_m_data, '0);
        chk_eq({tag, "_busy"}, busy, 1'b0);
        chk_eq({tag, "_sync_err"}, sync_err, 1'b0);
`ifdef BOXCAR_SEQ_CTRL_STATS_EN
        chk_eq({tag, "_acc_cnt"}, acc_cnt, '0);
        chk_eq({tag, "_drop_cnt"}, drop_cnt, '0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_s_valid = 1'b0;
        bus.i_s_data  = '0;
        bus.i_m_ready = 1'b0;

        // Reset values, then release and expect the filter reset to deassert on the first edge.
        #12;
        chk_reset_outs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_eq("post_rst_filt_rst_n", filt_reset_n, 1'b1);
        chk_eq("post_rst_busy", busy, 1'b0);

        // Basic stream 1,2,3,4 with div=1, output latency of 3 cycles.
        do_start(8'd1);
        send_one(8'd1);
        send_one(8'd2);
        send_one(8'd3);
        chk_eq("lat_t1", bus.o_m_valid, 1'b0);
        step();
        chk_eq("lat_t2", bus.o_m_valid, 1'b0);
        step();
        chk_eq("lat_t3_valid", bus.o_m_valid, 1'b1);
        chk_eq("lat_t3_data", bus.o_m_data, 9'd2);
        send_one(8'd4);
        repeat (4) step();
        chk_eq("a_sync_err", sync_err, 1'b0);
        do_stop();
        drain(40);

        // Decimation by 3: 11 samples of 4 give 9 expected, 3 forwarded.
        bus.i_m_ready = 1'b1;
        do_start(8'd3);
        for (int i = 0; i < 11; i++) send_one(8'd4);
        repeat (4) step();
        do_stop();
        drain(40);
        chk_eq("b_drop_model", m_drop, 6);
`ifdef BOXCAR_SEQ_CTRL_STATS_EN
        chk_eq("b_accept_cnt", acc_cnt, m_acc);
        chk_eq("b_drop_cnt", drop_cnt, m_drop);
`endif

        // Random traffic: div=0 (treated as 1), then a random divisor.
        do_start(8'd0);
        stream(150, 70, 60);
        do_stop();
        drain(60);
        do_start(DIVW'($urandom_range(2, 5)));
        stream(150, 80, 50);
        do_stop();
        drain(60);
        chk_eq("rand_sync_err", sync_err, 1'b0);
`ifdef BOXCAR_SEQ_CTRL_STATS_EN
        chk_eq("rand_accept_cnt", acc_cnt, m_acc);
        chk_eq("rand_drop_cnt", drop_cnt, m_drop);
`endif

        // Backpressure: downstream stalled, continuous input.
        do_start(8'd1);
        stream(12, 100, 0);
        chk_eq("bp_ready", bus.o_s_ready, 1'b0);
        chk_eq("bp_held", exp_q.size(), 4);
        chk_eq("bp_m_valid", bus.o_m_valid, 1'b1);
        do_stop();
        drain(40);

        // Stop in the same cycle as an accept; result survives into IDLE.
        bus.i_m_ready = 1'b0;
        do_start(8'd1);
        send_one(8'd10);
        send_one(8'd20);
        chk_eq("stop_acc_ready", bus.o_s_ready, 1'b1);
        bus.i_s_valid = 1'b1;
        bus.i_s_data  = 8'd30;
        do_stop();
        bus.i_s_valid = 1'b0;
        chk_eq("stop_busy_drain", busy, 1'b1);
        repeat (2) step();
        chk_eq("stop_idle", busy, 1'b0);
        chk_eq("stop_fifo_kept", bus.o_m_valid, 1'b1);
        chk_eq("stop_fifo_data", bus.o_m_data, 9'd25);
        drain(40);

        // Filter strobing during warm-up flags a sticky sync error.
        bus.i_m_ready = 1'b1;
        glitch = 1'b1;
        do_start(8'd1);
        send_one(8'd1);
        send_one(8'd2);
        send_one(8'd3);
        glitch = 1'b0;
        repeat (3) step();
        chk_eq("sync_err_set", sync_err, 1'b1);
        do_stop();
        drain(40);
        repeat (3) step();
        chk_eq("sync_err_sticky", sync_err, 1'b1);
        do_start(8'd1);
        chk_eq("sync_err_cleared", sync_err, 1'b0);
        do_stop();
        drain(20);

        // Asynchronous reset mid-RUN with three results buffered.
        bus.i_m_ready = 1'b0;
        do_start(8'd1);
        for (int i = 0; i < 5; i++) send_one(DW'(5 + i));
        repeat (2) step();
        send_one(8'd10);
        chk_eq("pre_rst_filt_ce", filt_ce, 1'b1);
        chk_eq("pre_rst_m_valid", bus.o_m_valid, 1'b1);
        chk_eq("pre_rst_held", exp_q.size(), 4);
        #2;
        rst_n = 1'b0;
        run_flag = 1'b0;
        #1;
        chk_reset_outs("mid_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_eq("restart_filt_rst_n", filt_reset_n, 1'b1);
        bus.i_m_ready = 1'b1;
        do_start(8'd1);
        send_one(8'd1);
        send_one(8'd2);
        send_one(8'd3);
        send_one(8'd4);
        repeat (4) step();
        chk_eq("restart_sync_err", sync_err, 1'b0);
        do_stop();
        drain(40);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/boxcar_seq_ctrl.md
# boxcar_seq_ctrl

Sequencer and stream adapter for a single boxcar (moving-average) filter instance. It accepts samples on a valid/ready stream and drives the filter's clock-enable, data and synchronous reset. It tracks window warm-up and decimates the filter output by a runtime divisor, buffering forwarded results in a small FIFO with backpressure. It sits between the sample source and downstream DSP, owning the filter's start/flush/run/drain sequencing.

## Interface
- DATA_WIDTH, 8, input sample width (signed)
- NUM_SAMPLES, 2, filter window length; also the warm-up sample count
- OUT_WIDTH, DATA_WIDTH+$clog2(NUM_SAMPLES), filter result width
- DIV_WIDTH, 8, decimation divisor width
- FIFO_DEPTH, 4, output FIFO entries (power of two, ≥2)

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  reset; asynchronous assert, active-low
- i_start  in  1  start pulse; latches i_div
- i_stop  in  1  stop pulse
- i_div  in  DIV_WIDTH  decimation divisor; 0 treated as 1
- i_s_valid / o_s_ready  in/out  1  input handshake
- i_s_data  in  DATA_WIDTH  input sample
- o_filt_reset_n  out  1  filter synchronous reset, active-low
- o_filt_ce  out  1  filter clock-enable
- o_filt_data  out  DATA_WIDTH  filter input sample
- i_filt_ce  in  1  filter output strobe
- i_filt_data  in  OUT_WIDTH  filter result
- o_m_valid / i_m_ready  out/in  1  output handshake
- o_m_data  out  OUT_WIDTH  decimated result
- o_busy  out  1  state != IDLE
- o_sync_err  out  1  sticky: i_filt_ce disagreed with expected strobe

## Operation
- FSM: IDLE, FLUSH, RUN, DRAIN.
- IDLE → FLUSH on i_start (i_stop same cycle has priority: stay IDLE). Latch div_q = max(i_div,1). Clear warm-up and decimation counters and o_sync_err.
- FLUSH: o_filt_reset_n=0 for exactly 2 cycles, then RUN.
- RUN:
  - Accept when i_s_valid && o_s_ready.
  - o_s_ready = RUN && (fifo_count + inflight) < FIFO_DEPTH.
  - i_start ignored. i_stop → DRAIN (a sample accepted in the same cycle is still processed).
- DRAIN: o_s_ready=0. Go to IDLE once inflight==0. FIFO contents remain readable in IDLE.
- Each accepted sample gets a shadow "expected" bit, pushed into a 2-stage shadow pipe:
  - Expected = 0 for the first NUM_SAMPLES accepted samples after FLUSH (warm-up).
  - Expected = 1 thereafter.
- Decimation: among expected outputs, a counter 0..div_q-1 forwards only when the counter is 0, then wraps.
- At the shadow pipe end:
  - If expected && forward: write i_filt_data into the FIFO.
  - If i_filt_ce != expected: set o_sync_err.
- inflight = number of expected-and-forwarded entries still in the shadow pipe (0..2).
- Arithmetic: decimation counter DIV_WIDTH bits, wraps at div_q-1. Warm-up counter saturates at NUM_SAMPLES.
- FIFO: simultaneous push and pop when full is legal, because the pop frees the slot. Pop on o_m_valid && i_m_ready.

## Timing
- Sample accepted at cycle t:
  - t+1: o_filt_ce=1, o_filt_data = sample (registered).
  - t+2: i_filt_ce/i_filt_data sampled.
  - t+3: o_m_valid=1 with that result if the FIFO was empty.
- Result latency: 3 cycles input-to-output. Throughput: 1 sample/cycle while downstream is ready.
- o_filt_ce=0 whenever no sample was accepted the previous cycle.
- Reset (asynchronous, mid-operation included): state=IDLE, FIFO emptied, shadow pipe cleared, div_q=1.
- Output values during reset: o_s_ready=0, o_filt_ce=0, o_filt_reset_n=0, o_filt_data=0, o_m_valid=0, o_m_data=0, o_busy=0, o_sync_err=0.
- On reset release: o_filt_reset_n=1 from the first clock edge. o_filt_reset_n=0 otherwise only in FLUSH.

## Configuration
- BOXCAR_SEQ_CTRL_STATS_EN defined: adds output o_accept_count[15:0] (accepted samples) and o_drop_count[15:0] (expected results discarded by decimation).
  - Both saturate at 16'hFFFF.
  - Both clear on reset and on IDLE→FLUSH.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Reset, i_start with i_div=1, NUM_SAMPLES=2, stream 1,2,3,4, filter model attached → o_filt_reset_n low 2 cycles; first 2 samples produce no output; outputs 2,3 (window sums >>1); o_sync_err=0.
- i_div=3, 11 samples of value 4 → (11-2)=9 expected results, 3 forwarded (all 4); o_drop_count=6 with STATS_EN.
- i_m_ready=0 with continuous i_s_valid, i_div=1, after warm-up → o_s_ready drops once fifo_count+inflight=4; exactly 4 results held; none lost after i_m_ready=1.
- i_stop asserted the same cycle as a sample accept → that result still appears; state goes DRAIN→IDLE within 2 cycles; o_busy=0; FIFO still drains.
- Filter model strobes i_filt_ce during warm-up → o_sync_err=1 and sticky until the next i_start.
- Assert i_reset_n=0 mid-RUN with 3 FIFO entries → o_m_valid=0, o_busy=0, o_filt_ce=0 immediately (asynchronous); restart yields a clean warm-up.
